// File: rtl/aud_pkg.sv
// Shared types and default sizes for the audio recorder blocks.
// Imported by aud_shift_in and aud_recorder.
package aud_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 20;
  localparam int CNT_W    = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_L = 3'd1,
    SHIFT  = 3'd2,
    STORE  = 3'd3,
    WAIT_H = 3'd4,
    PAUSED = 3'd5
  } state_t;

endpackage

// File: rtl/aud_shift_in.sv
// Serial-in, MSB-first word shifter with a bit counter and a last-bit pulse.
// word_next already includes the bit presented this cycle, so the owner can latch it on done.
module aud_shift_in
  #(
    parameter int W = aud_pkg::SAMPLE_W
  ) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] word_next,
    output logic         done
  );
  import aud_pkg::*;

  logic [W-2:0]     shreg;
  logic [CNT_W-1:0] cnt;

  assign word_next = {shreg, din};
  assign done      = en && (cnt == CNT_W'(W - 1));

  // shift register and bit counter; clear wins over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (en) begin
      shreg <= word_next[W-2:0];
      cnt   <= cnt + CNT_W'(1);
    end else begin
      shreg <= shreg;
      cnt   <= cnt;
    end
  end

endmodule

// File: rtl/aud_recorder.sv
// I2S left-channel capture into sample SRAM with auto-incrementing address.
// Optional clip flag output enabled by AUD_REC_CLIP_DETECT_EN.
module aud_recorder
  #(
    parameter int                ADDR_W   = aud_pkg::ADDR_W,
    parameter int                SAMPLE_W = aud_pkg::SAMPLE_W,
    parameter logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}}
  ) (
    input  logic                i_rst_n,
    input  logic                i_bclk,
    input  logic                i_lrc,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    input  logic                i_data,
    output logic [ADDR_W-1:0]   o_address,
    output logic [SAMPLE_W-1:0] o_data,
    output logic                o_wr,
    output logic [ADDR_W:0]     o_len,
    output logic                o_busy,
    output logic                o_full
`ifdef AUD_REC_CLIP_DETECT_EN
    ,
    output logic                o_clip
`endif
  );
  import aud_pkg::*;

  state_t              state, state_nxt;
  logic                lrc_d, pause_pending, pend_nxt, e0, pause_req;
  logic                shift_clear, shift_en, shift_done;
  logic [SAMPLE_W-1:0] word_next, data_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [ADDR_W:0]     len_nxt;
  logic                wr_nxt, full_nxt;

  assign e0          = lrc_d && !i_lrc;
  assign pause_req   = i_pause || pause_pending;
  assign shift_clear = (state == WAIT_L);
  assign shift_en    = (state == SHIFT) && !i_stop;

  aud_shift_in #(.W(SAMPLE_W)) u_shift (
    .clk       (i_bclk),
    .rst_n     (i_rst_n),
    .clear     (shift_clear),
    .en        (shift_en),
    .din       (i_data),
    .word_next (word_next),
    .done      (shift_done)
  );

  // state register
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state: stop beats pause beats start
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = WAIT_L; else state_nxt = IDLE;
      WAIT_L:  if (i_stop) state_nxt = IDLE;
               else if (pause_req) state_nxt = PAUSED;
               else if (e0) state_nxt = SHIFT;
               else state_nxt = WAIT_L;
      SHIFT:   if (i_stop) state_nxt = IDLE;
               else if (shift_done) state_nxt = STORE;
               else state_nxt = SHIFT;
      STORE:   if (i_stop) state_nxt = IDLE;
               else if (o_address == ADDR_MAX) state_nxt = IDLE;
               else if (pause_req) state_nxt = PAUSED;
               else state_nxt = WAIT_H;
      WAIT_H:  if (i_stop) state_nxt = IDLE;
               else if (pause_req) state_nxt = PAUSED;
               else if (i_lrc) state_nxt = WAIT_L;
               else state_nxt = WAIT_H;
      PAUSED:  if (i_stop) state_nxt = IDLE;
               else if (i_start) state_nxt = WAIT_L;
               else state_nxt = PAUSED;
      default: state_nxt = IDLE;
    endcase
  end

  // output/datapath next values; a stop discards partial words and freezes counters
  always_comb begin
    addr_nxt = o_address;
    len_nxt  = o_len;
    data_nxt = o_data;
    wr_nxt   = 1'b0;
    full_nxt = o_full;
    pend_nxt = pause_pending;
    case (state)
      IDLE: begin
        if (i_start) begin
          addr_nxt = '0;
          len_nxt  = '0;
          full_nxt = 1'b0;
        end else begin
          full_nxt = o_full;
        end
      end
      SHIFT: begin
        if (i_stop) begin
          pend_nxt = 1'b0;
        end else begin
          pend_nxt = pause_req;
          if (shift_done) begin
            data_nxt = word_next;
            wr_nxt   = 1'b1;
          end else begin
            data_nxt = o_data;
          end
        end
      end
      STORE: begin
        pend_nxt = 1'b0;
        if (i_stop) begin
          len_nxt = o_len;
        end else begin
          len_nxt = o_len + {{ADDR_W{1'b0}}, 1'b1};
          if (o_address == ADDR_MAX) full_nxt = 1'b1;
          else addr_nxt = o_address + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      WAIT_L, WAIT_H, PAUSED: pend_nxt = 1'b0;
      default: wr_nxt = 1'b0;
    endcase
  end

  // registered outputs
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_address     <= '0;
      o_data        <= '0;
      o_wr          <= 1'b0;
      o_len         <= '0;
      o_busy        <= 1'b0;
      o_full        <= 1'b0;
      lrc_d         <= 1'b1;
      pause_pending <= 1'b0;
    end else begin
      o_address     <= addr_nxt;
      o_data        <= data_nxt;
      o_wr          <= wr_nxt;
      o_len         <= len_nxt;
      o_busy        <= (state_nxt != IDLE);
      o_full        <= full_nxt;
      lrc_d         <= i_lrc;
      pause_pending <= pend_nxt;
    end
  end

`ifdef AUD_REC_CLIP_DETECT_EN
  localparam logic [SAMPLE_W-1:0] CLIP_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] CLIP_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  logic clip_nxt;

  // sticky full-scale flag, cleared only by a fresh recording
  always_comb begin
    clip_nxt = o_clip;
    if (state == IDLE && i_start) clip_nxt = 1'b0;
    else if (state == STORE && !i_stop && (o_data == CLIP_POS || o_data == CLIP_NEG)) clip_nxt = 1'b1;
    else clip_nxt = o_clip;
  end

  // clip flag register
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) o_clip <= 1'b0;
    else          o_clip <= clip_nxt;
  end
`endif

endmodule
